// File: rtl/elevator_scan_ctrl_if.sv
// Button/lamp and car-status bundle for the LOOK elevator controller.
// slave: the controller (takes calls, drives status); master: buttons, lamps, drivers.
interface elevator_scan_ctrl_if #(
    parameter int N_FLOORS = 10
);
    localparam int FLOOR_W = $clog2(N_FLOORS);

    logic [N_FLOORS-1:0] hall_up_i;
    logic [N_FLOORS-1:0] hall_down_i;
    logic [N_FLOORS-1:0] car_call_i;
    logic                hold_door_i;
    logic [FLOOR_W-1:0]  floor_o;
    logic [1:0]          direction_o;
    logic                door_open_o;
    logic                request_served_o;
    logic [N_FLOORS-1:0] pend_up_o;
    logic [N_FLOORS-1:0] pend_down_o;
    logic [N_FLOORS-1:0] pend_car_o;
    // Debug view of the controller state: 0 IDLE, 1 MOVE, 2 ARRIVE, 3 DOOR_OPEN
    logic [1:0]          state_o;

    modport slave (
        input  hall_up_i, hall_down_i, car_call_i, hold_door_i,
        output floor_o, direction_o, door_open_o, request_served_o,
        output pend_up_o, pend_down_o, pend_car_o, state_o
    );

    modport master (
        output hall_up_i, hall_down_i, car_call_i, hold_door_i,
        input  floor_o, direction_o, door_open_o, request_served_o,
        input  pend_up_o, pend_down_o, pend_car_o, state_o
    );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller with a LOOK sweep: latches hall and car calls
// per floor, travels toward pending calls, keeps sweeping in one direction
// while calls remain ahead, and times the door dwell with hold extension.
module elevator_scan_ctrl #(
    parameter int  N_FLOORS      = 10,
    parameter int  TRAVEL_CYCLES = 4,
    parameter int  DOOR_CYCLES   = 3,
    localparam int FLOOR_W       = $clog2(N_FLOORS)
) (
    input logic           clk_i,
    input logic           rst_i,
    elevator_scan_ctrl_if.slave bus
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
    // A hold/re-press cycle counts as the first cycle of the restarted dwell,
    // so the door closes DOOR_CYCLES-1 cycles after the last such cycle.
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'((DOOR_CYCLES > 1) ? DOOR_CYCLES - 2 : 0);

    // No up call from the top floor, no down call from the bottom floor.
    localparam logic [N_FLOORS-1:0] UP_MASK   = ~(N_FLOORS'(1) << (N_FLOORS - 1));
    localparam logic [N_FLOORS-1:0] DOWN_MASK = ~N_FLOORS'(1);

    localparam logic [1:0] DIR_UP   = 2'b11;
    localparam logic [1:0] DIR_DOWN = 2'b00;
    localparam logic [1:0] DIR_STOP = 2'b01;

    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, ARRIVE = 2'd2, DOOR_OPEN = 2'd3} state_t;
    typedef enum logic [1:0] {SWEEP_NONE = 2'd0, SWEEP_UP = 2'd1, SWEEP_DOWN = 2'd2} sweep_t;

    state_t              state;
    sweep_t              sweep;
    logic [FLOOR_W-1:0]  floor;
    logic [CNT_W-1:0]    cnt;
    logic [N_FLOORS-1:0] pend_up, pend_down, pend_car;
    logic [1:0]          direction;
    logic                door_open, served;

    logic [N_FLOORS-1:0] floor_oh, above_mask, below_mask, pend_any;
    logic [N_FLOORS-1:0] press_up, press_down, press_car;
    logic [N_FLOORS-1:0] absorb_up, absorb_down, absorb_car;
    logic [N_FLOORS-1:0] clr_up, clr_down, clr_car;
    logic above, below, here, car_here, up_here, down_here;
    logic going_down, further, behind, sweep_hall_here, opp_hall_here;
    logic arrive_stop, arrive_opp_only, absorbed, door_reload, door_done, flip_at_door;

    function automatic logic [1:0] dir_of(input sweep_t s);
        case (s)
            SWEEP_UP:   return DIR_UP;
            SWEEP_DOWN: return DIR_DOWN;
            default:    return DIR_STOP;
        endcase
    endfunction

    // Call-position summary, LOOK stop/turn decisions and per-cycle clear masks.
    always_comb begin
        floor_oh   = '0;
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            floor_oh[i]   = (i == int'(floor));
            above_mask[i] = (i > int'(floor));
            below_mask[i] = (i < int'(floor));
        end
        pend_any  = pend_up | pend_down | pend_car;
        above     = |(pend_any & above_mask);
        below     = |(pend_any & below_mask);
        here      = |(pend_any & floor_oh);
        car_here  = |(pend_car & floor_oh);
        up_here   = |(pend_up & floor_oh);
        down_here = |(pend_down & floor_oh);

        // With no sweep the car looks upward first.
        going_down      = (sweep == SWEEP_DOWN);
        further         = going_down ? below : above;
        behind          = going_down ? above : below;
        sweep_hall_here = going_down ? down_here : up_here;
        opp_hall_here   = going_down ? up_here : down_here;

        arrive_stop     = car_here | sweep_hall_here | (!further & here);
        arrive_opp_only = !car_here & !sweep_hall_here & opp_hall_here;

        press_up   = bus.hall_up_i & UP_MASK;
        press_down = bus.hall_down_i & DOWN_MASK;
        press_car  = bus.car_call_i;

        // While the door is open, presses for the categories just served here
        // only extend the dwell instead of re-latching.
        absorb_up   = '0;
        absorb_down = '0;
        absorb_car  = '0;
        if (state == DOOR_OPEN) begin
            absorb_car = press_car & floor_oh;
            if (sweep != SWEEP_DOWN) absorb_up = press_up & floor_oh;
            if (sweep != SWEEP_UP)   absorb_down = press_down & floor_oh;
        end
        absorbed     = |(absorb_up | absorb_down | absorb_car);
        door_reload  = bus.hold_door_i | absorbed;
        door_done    = (state == DOOR_OPEN) && (cnt == '0) && !door_reload;
        flip_at_door = door_done && !further && !behind && opp_hall_here && (sweep != SWEEP_NONE);

        clr_up   = '0;
        clr_down = '0;
        clr_car  = '0;
        case (state)
            IDLE: begin
                if (here) begin
                    clr_up   = floor_oh;
                    clr_down = floor_oh;
                    clr_car  = floor_oh;
                end
            end
            ARRIVE: begin
                if (arrive_stop) begin
                    clr_car = floor_oh;
                    if (arrive_opp_only ^ going_down) clr_down = floor_oh;
                    else                              clr_up   = floor_oh;
                end
            end
            DOOR_OPEN: begin
                if (flip_at_door) begin
                    if (going_down) clr_up   = floor_oh;
                    else            clr_down = floor_oh;
                end
            end
            default: ;
        endcase
    end

    // Call latching plus the IDLE/MOVE/ARRIVE/DOOR_OPEN state machine with registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            sweep     <= SWEEP_NONE;
            floor     <= '0;
            cnt       <= '0;
            pend_up   <= '0;
            pend_down <= '0;
            pend_car  <= '0;
            direction <= DIR_STOP;
            door_open <= 1'b0;
            served    <= 1'b0;
        end else begin
            // A clear in the same cycle as a press for that bit wins.
            pend_up   <= (pend_up   | (press_up   & ~absorb_up))   & ~clr_up;
            pend_down <= (pend_down | (press_down & ~absorb_down)) & ~clr_down;
            pend_car  <= (pend_car  | (press_car  & ~absorb_car))  & ~clr_car;
            served    <= 1'b0;

            case (state)
                IDLE: begin
                    if (here) begin
                        state     <= DOOR_OPEN;
                        cnt       <= DOOR_LOAD;
                        door_open <= 1'b1;
                        served    <= 1'b1;
                        direction <= DIR_STOP;
                    end else if (above && (sweep != SWEEP_DOWN || !below)) begin
                        state     <= MOVE;
                        sweep     <= SWEEP_UP;
                        cnt       <= TRAVEL_LOAD;
                        direction <= DIR_UP;
                    end else if (below) begin
                        state     <= MOVE;
                        sweep     <= SWEEP_DOWN;
                        cnt       <= TRAVEL_LOAD;
                        direction <= DIR_DOWN;
                    end else begin
                        sweep     <= SWEEP_NONE;
                        direction <= DIR_STOP;
                    end
                end
                MOVE: begin
                    if (cnt == '0) begin
                        floor <= going_down ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);
                        state <= ARRIVE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ARRIVE: begin
                    if (arrive_stop) begin
                        state     <= DOOR_OPEN;
                        cnt       <= DOOR_LOAD;
                        door_open <= 1'b1;
                        served    <= 1'b1;
                        direction <= DIR_STOP;
                        if (arrive_opp_only) sweep <= going_down ? SWEEP_UP : SWEEP_DOWN;
                    end else begin
                        state <= MOVE;
                        cnt   <= TRAVEL_LOAD;
                    end
                end
                DOOR_OPEN: begin
                    if (door_reload) begin
                        cnt <= HOLD_LOAD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (further) begin
                        state     <= MOVE;
                        sweep     <= going_down ? SWEEP_DOWN : SWEEP_UP;
                        direction <= going_down ? DIR_DOWN : DIR_UP;
                        cnt       <= TRAVEL_LOAD;
                        door_open <= 1'b0;
                    end else if (behind) begin
                        state     <= MOVE;
                        sweep     <= going_down ? SWEEP_UP : SWEEP_DOWN;
                        direction <= going_down ? DIR_UP : DIR_DOWN;
                        cnt       <= TRAVEL_LOAD;
                        door_open <= 1'b0;
                    end else if (flip_at_door) begin
                        sweep  <= going_down ? SWEEP_UP : SWEEP_DOWN;
                        cnt    <= DOOR_LOAD;
                        served <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        sweep     <= SWEEP_NONE;
                        direction <= dir_of(SWEEP_NONE);
                        cnt       <= '0;
                        door_open <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.floor_o          = floor;
    assign bus.direction_o      = direction;
    assign bus.door_open_o      = door_open;
    assign bus.request_served_o = served;
    assign bus.pend_up_o        = pend_up;
    assign bus.pend_down_o      = pend_down;
    assign bus.pend_car_o       = pend_car;
    assign bus.state_o          = state;

endmodule

// File: doc/elevator_scan_ctrl.md
# elevator_scan_ctrl

Parametrised next-generation single-car elevator controller implementing a LOOK sweep policy. Hall calls (up/down) and car calls are latched into per-floor pending registers. The car travels with a programmable per-floor travel time and holds its door open for a programmable dwell with a door-hold extension. It sits between the floor-button/lamp interface and the motor/door drivers and exposes pending-call status for lamp driving.

## Interface
- N_FLOORS, 10, number of floors (≥2); floors numbered 0..N_FLOORS-1
- TRAVEL_CYCLES, 4, clock cycles spent in MOVE per floor (≥1)
- DOOR_CYCLES, 3, door dwell in cycles (≥1)
- FLOOR_W, $clog2(N_FLOORS), floor index width (derived; do not override)

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- hall_up_i  in  N_FLOORS  up-call buttons, one bit per floor; bit N_FLOORS-1 ignored
- hall_down_i  in  N_FLOORS  down-call buttons; bit 0 ignored
- car_call_i  in  N_FLOORS  in-car destination buttons
- hold_door_i  in  1  door-hold; reloads dwell timer while door open
- floor_o  out  FLOOR_W  current floor
- direction_o  out  2  2'b11 going up, 2'b00 going down, 2'b01 stationary
- door_open_o  out  1  door open
- request_served_o  out  1  one-cycle pulse on first door-open cycle
- pend_up_o / pend_down_o / pend_car_o  out  N_FLOORS each  latched call status (lamps)

## Operation
- Latching: every cycle pend_up |= hall_up_i (top bit masked), pend_down |= hall_down_i (bit 0 masked), pend_car |= car_call_i. Inputs may be pulses or levels.
- Sweep register: UP, DOWN or NONE.
- Derived terms: above = any pending bit (any type) at floors > floor. below = the same for floors < floor. here = any pending bit at floor.
- States: IDLE, MOVE, ARRIVE, DOOR_OPEN.
- IDLE, evaluated in priority order:
  - here → DOOR_OPEN; clear all three bits at floor.
  - above and (sweep≠DOWN or !below) → MOVE, sweep=UP.
  - below → MOVE, sweep=DOWN.
  - otherwise stay in IDLE, sweep=NONE.
- MOVE: travel counter loads TRAVEL_CYCLES-1 on entry and decrements to 0. At 0, floor ±1 per sweep → ARRIVE.
- ARRIVE: one-cycle stop decision. Stop when any of these holds:
  - pend_car[f].
  - The sweep-direction hall bit at f.
  - No pending call further in the sweep direction and any call at f.
- On stop → DOOR_OPEN; clear pend_car[f] and the sweep-direction hall bit. If stopping only for the opposite hall bit, flip sweep and clear that bit. No stop → MOVE, same sweep.
- DOOR_OPEN: dwell counter loads DOOR_CYCLES-1 on entry; hold_door_i reloads it. A new press at the current floor matching a cleared category (car, or hall in current sweep) reloads the dwell and is not latched. On expiry, in priority order:
  - Calls further in sweep → MOVE.
  - Calls behind → flip sweep, MOVE.
  - Opposite hall bit at floor → flip sweep, clear it, stay in DOOR_OPEN with dwell reloaded and a new served pulse.
  - Otherwise → IDLE, sweep=NONE.
- Bounds: floor never leaves 0..N_FLOORS-1, since the car moves only toward a pending call.
- Counters sized for max(TRAVEL_CYCLES, DOOR_CYCLES)-1; no wrap.

## Timing
- Reset (asynchronous, immediate, mid-operation included):
  - floor_o=0, direction_o=2'b01, door_open_o=0, request_served_o=0.
  - All pend_* =0, state IDLE, sweep NONE, counters 0.
- All outputs are registered.
- Call latency: a press in cycle t is visible on pend_*_o in cycle t+1, and state leaves IDLE in cycle t+2.
- direction_o=UP/DOWN in MOVE and ARRIVE; 2'b01 in IDLE and DOOR_OPEN.
- floor_o updates in the first ARRIVE cycle.
- Per-floor transit: TRAVEL_CYCLES + 1 cycles.
- door_open_o is high for exactly DOOR_CYCLES cycles absent hold. request_served_o coincides with the first of those cycles. Pending bits read cleared in the same cycle.
- Simultaneous clear and press for the same bit in the clearing cycle: the clear wins (press absorbed).

## Test plan
- Reset during MOVE at floor 3 → next cycle all outputs equal their reset values, with no clock edge required.
- Idle at floor 0, hall_up_i[2] pulsed at t0 (TRAVEL=4, DOOR=3):
  - t1: pend_up_o[2]=1.
  - t2: direction_o=11.
  - t6: floor_o=1.
  - t11: floor_o=2.
  - t12: door_open_o=1, request_served_o=1, pend_up_o[2]=0.
  - t15: IDLE, direction_o=01.
- Going up from 0 with car_call 5 and hall_down 3 pending → passes floor 3 without stopping, stops at 5, reverses, stops at 3 and clears pend_down_o[3].
- Door open at floor 4, hold_door_i high for 5 cycles → door_open_o stays high for 5+DOOR_CYCLES-1 cycles.
- Car at floor 0, hall_down_i[0]=1 and hall_up_i[N_FLOORS-1]=1 → masked bits never latch; car remains IDLE.
- Idle at floor 4 with calls at 2 and 6 latched in the same cycle → sweep NONE gives up priority: serves 6, then 2.
